mult_div_unit: RTL

- Multi-cycle integer multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the two register-file read operands and produces the 64-bit result into the HI/LO register pair.
- Supports mult, multu, div and divu, plus mthi/mtlo writes, through a start/busy/done handshake.
- Control decodes the instruction. The datapath stalls on busy and reads hi/lo for mfhi/mflo.

---
 rtl/mult_div_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit that produces the HI/LO pair, with mthi/mtlo writes.
// Optional macro MDU_FAST_MULT_EN: multiplies finish in one RUN edge using a combinational product.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         wen_hi,
    input  logic         wen_lo,
    input  logic [N-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    state_e          state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [N-1:0]    mag_a_q, mag_a_d;
    logic [N-1:0]    mag_b_q, mag_b_d;
    // Multiply: {partial product, remaining multiplier}. Divide: low half shifts dividend out / quotient in.
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            a_neg_s;
    logic            b_neg_s;
    logic [N:0]      rem_shift_s;
    logic [2*N-1:0]  prod_s;
`ifndef MDU_FAST_MULT_EN
    logic [N:0]      sum_s;
`endif

    // Next-state, datapath iteration and HI/LO update logic.
    always_comb begin
        state_d     = state_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        a_neg_s     = op[0] & inA[N-1];
        b_neg_s     = op[0] & inB[N-1];
        rem_shift_s = {rem_q, acc_q[N-1]};
        prod_s      = neg_res_q ? neg_2n(acc_q) : acc_q;
`ifndef MDU_FAST_MULT_EN
        sum_s       = {1'b0, acc_q[2*N-1:N]} + ({1'b0, mag_a_q} & {(N+1){acc_q[0]}});
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    mag_a_d   = a_neg_s ? neg_n(inA) : inA;
                    mag_b_d   = b_neg_s ? neg_n(inB) : inB;
                    rem_d     = {N{1'b0}};
                    cnt_d     = {CW{1'b0}};
                    busy_d    = 1'b1;
                    dbz_d     = 1'b0;
                    if (op[1]) begin
                        acc_d = {{N{1'b0}}, mag_a_d};
                    end else begin
                        acc_d = {{N{1'b0}}, mag_b_d};
                    end
                    // A zero divisor bypasses the iterations entirely.
                    if (op[1] && (inB == {N{1'b0}})) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    if (wen_hi) begin
                        hi_d = wd;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (wen_lo) begin
                        lo_d = wd;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1'b1);
                if (is_div_q) begin
                    if (rem_shift_s >= {1'b0, mag_b_q}) begin
                        rem_d = N'(rem_shift_s - {1'b0, mag_b_q});
                        acc_d = {acc_q[2*N-1:N], acc_q[N-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift_s[N-1:0];
                        acc_d = {acc_q[2*N-1:N], acc_q[N-2:0], 1'b0};
                    end
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
`ifdef MDU_FAST_MULT_EN
                    acc_d   = {{N{1'b0}}, mag_a_q} * {{N{1'b0}}, mag_b_q};
                    state_d = ST_FINISH;
`else
                    acc_d = {sum_s, acc_q[N-1:1]};
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
`endif
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (is_div_q && (mag_b_q == {N{1'b0}})) begin
                    // Restoring the sign of the magnitude gives back the original dividend.
                    hi_d  = neg_rem_q ? neg_n(mag_a_q) : mag_a_q;
                    lo_d  = {N{1'b1}};
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_res_q ? neg_n(acc_q[N-1:0]) : acc_q[N-1:0];
                    hi_d = neg_rem_q ? neg_n(rem_q) : rem_q;
                end else begin
                    hi_d = prod_s[2*N-1:N];
                    lo_d = prod_s[N-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_a_q   <= {N{1'b0}};
            mag_b_q   <= {N{1'b0}};
            acc_q     <= {(2*N){1'b0}};
            rem_q     <= {N{1'b0}};
            cnt_q     <= {CW{1'b0}};
            hi_q      <= {N{1'b0}};
            lo_q      <= {N{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
